multiplicador_secuencial: RTL and testbench

- Unsigned N×N → 2N-bit iterative shift-and-add multiplier with a start/busy/done handshake.
- Processes one multiplier bit per clock, so latency is fixed at N cycles.
- Used wherever a small-area multiplier is preferred over a combinational array.
- `result` holds the last product until the next completed operation.

---
 rtl/multiplicador_secuencial.sv | 156 +++++++++++++++
 tb/tb_multiplicador_secuencial.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_secuencial.sv
// Iterative shift-and-add N x N -> 2N multiplier, one multiplier bit per clock.
// Optional `MULT_SIGNED_EN: two's-complement operands via sign/magnitude.
`timescale 1ns/1ps

module multiplicador_secuencial #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] result,
    output logic           busy,
    output logic           done
);

    localparam int W  = 2 * N;
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           done_q, done_d;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [W-1:0]   addend;
    logic [W-1:0]   acc_sum;
    logic [W-1:0]   prod_final;

`ifdef MULT_SIGNED_EN
    logic           sign_q, sign_d;
    logic           sign_in;

    // Operand magnitudes and product sign; -2^(N-1) maps to 2^(N-1) unsigned
    always_comb begin
        a_mag   = a[N-1] ? (~a + N'(1)) : a;
        b_mag   = b[N-1] ? (~b + N'(1)) : b;
        sign_in = a[N-1] ^ b[N-1];
    end
`else
    // Unsigned build: operands are used as-is
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // Conditional add of the shifted multiplicand for the current bit
    always_comb begin
        addend  = mplier_q[0] ? mcand_q : '0;
        acc_sum = acc_q + addend;
    end

`ifdef MULT_SIGNED_EN
    // Re-apply the product sign at completion
    always_comb begin
        prod_final = sign_q ? (~acc_sum + W'(1)) : acc_sum;
    end
`else
    // Final product is the accumulator after the last step
    always_comb begin
        prod_final = acc_sum;
    end
`endif

    // FSM next-state and datapath update
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef MULT_SIGNED_EN
        sign_d   = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{N{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MULT_SIGNED_EN
                    sign_d   = sign_in;
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = prod_final;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

`ifdef MULT_SIGNED_EN
    // Product sign captured with the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end
`endif

    assign result = result_q;
    assign busy   = (state_q == S_RUN);
    assign done   = done_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Scoreboard bench for multiplicador_secuencial (N = 8).
// Expected products are queued at issue and popped when done pulses.
`timescale 1ns/1ps

module tb_multiplicador_secuencial;

    localparam int N = 8;
    localparam int W = 2 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [W-1:0] result;
    logic         busy;
    logic         done;

    int n_vec  = 0;
    int n_miss = 0;
    logic [W-1:0] exp_q[$];

    multiplicador_secuencial #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [N-1:0] x,
                                           input logic [N-1:0] y);
`ifdef MULT_SIGNED_EN
        logic signed [W-1:0] p;
        p = $signed(x) * $signed(y);
        return p;
`else
        return W'(x) * W'(y);
`endif
    endfunction

    // Called at a negedge; returns at the negedge after start is sampled
    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges until done (bounded); bc counts busy-high samples
    task automatic wait_done(output int cyc, output int bc, output bit seen);
        cyc  = 0;
        bc   = busy ? 1 : 0;
        seen = 1'b0;
        while (cyc < 4 * N && !seen) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) bc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #2;
        n_vec++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_async: result=%h busy=%b done=%b want 0/0/0",
                     result, busy, done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_release: result=%h busy=%b done=%b want 0/0/0",
                     result, busy, done);
        end
    endtask

    task automatic test_basic;
        int cyc, bc;
        bit seen;
        logic [W-1:0] e;
        issue(8'h0A, 8'h05);
        wait_done(cyc, bc, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen) begin
            n_miss++;
            $display("FAIL basic_done: no done after %0d cycles", cyc);
        end
        n_vec++;
        if (result !== 16'h0032 || result !== e) begin
            n_miss++;
            $display("FAIL basic_result: got %h want %h", result, e);
        end
        n_vec++;
        if (cyc !== N || bc !== N || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_timing: cyc=%0d busy_cyc=%0d busy=%b want %0d/%0d/0",
                     cyc, bc, busy, N, N);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || result !== e) begin
            n_miss++;
            $display("FAIL basic_hold: done=%b result=%h want 0/%h", done, result, e);
        end
    endtask

    task automatic test_max;
        logic [N-1:0] xs[4];
        logic [N-1:0] ys[4];
        int cyc, bc;
        bit seen;
        logic [W-1:0] e;
        xs = '{8'hFF, 8'h00, 8'h01, 8'h80};
        ys = '{8'hFF, 8'h37, 8'hFF, 8'h02};
        for (int i = 0; i < 4; i++) begin
            issue(xs[i], ys[i]);
            wait_done(cyc, bc, seen);
            e = exp_q.pop_front();
            n_vec++;
            if (!seen || result !== e) begin
                n_miss++;
                $display("FAIL max_%0d: seen=%b result=%h want %h", i, seen, result, e);
            end
            n_vec++;
            if (cyc !== N || bc !== N) begin
                n_miss++;
                $display("FAIL max_lat_%0d: cyc=%0d busy_cyc=%0d want %0d", i, cyc, bc, N);
            end
        end
    endtask

    task automatic test_start_busy;
        int cyc, bc, extra;
        bit seen;
        logic [W-1:0] e;
        issue(8'h03, 8'h04);
        repeat (2) @(negedge clk);
        a = 8'h10;
        b = 8'h10;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen || result !== 16'h000C || result !== e) begin
            n_miss++;
            $display("FAIL busy_result: seen=%b result=%h want %h", seen, result, e);
        end
        n_vec++;
        if (cyc + 3 !== N) begin
            n_miss++;
            $display("FAIL busy_lat: total=%0d want %0d", cyc + 3, N);
        end
        extra = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_vec++;
        if (extra !== 0 || result !== e) begin
            n_miss++;
            $display("FAIL busy_restart: extra_cyc=%0d result=%h want 0/%h",
                     extra, result, e);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        bit seen;
        logic [W-1:0] e;
        issue(8'h02, 8'h03);
        wait_done(cyc, bc, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen || result !== 16'h0006 || result !== e) begin
            n_miss++;
            $display("FAIL b2b_first: seen=%b result=%h want %h", seen, result, e);
        end
        issue(8'h07, 8'h09);
        n_vec++;
        if (result !== e || busy !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_accept: result=%h busy=%b want %h/1", result, busy, e);
        end
        wait_done(cyc, bc, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen || result !== 16'h003F || result !== e) begin
            n_miss++;
            $display("FAIL b2b_second: seen=%b result=%h want %h", seen, result, e);
        end
        n_vec++;
        if (cyc + 1 !== N + 1) begin
            n_miss++;
            $display("FAIL b2b_gap: gap=%0d want %0d", cyc + 1, N + 1);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bc, extra;
        bit seen;
        logic [W-1:0] e;
        issue(8'h0A, 8'h05);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        n_vec++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_miss++;
            $display("FAIL rstmid_clear: result=%h busy=%b done=%b want 0/0/0",
                     result, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (done || busy || result !== '0) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_miss++;
            $display("FAIL rstmid_nodone: bad_cyc=%0d want 0", extra);
        end
        issue(8'h0A, 8'h05);
        wait_done(cyc, bc, seen);
        e = exp_q.pop_front();
        n_vec++;
        if (!seen || cyc !== N || result !== e) begin
            n_miss++;
            $display("FAIL rstmid_fresh: seen=%b cyc=%0d result=%h want %h",
                     seen, cyc, result, e);
        end
    endtask

    task automatic test_random;
        int cyc, bc;
        bit seen;
        logic [W-1:0] e;
        logic [N-1:0] x, y;
        for (int i = 0; i < 8; i++) begin
            x = N'($urandom);
            y = N'($urandom);
            issue(x, y);
            wait_done(cyc, bc, seen);
            e = exp_q.pop_front();
            n_vec++;
            if (!seen || cyc !== N || result !== e) begin
                n_miss++;
                $display("FAIL rand_%0d: %h*%h seen=%b cyc=%0d result=%h want %h",
                         i, x, y, seen, cyc, result, e);
            end
        end
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed;
        logic [N-1:0] xs[4];
        logic [N-1:0] ys[4];
        logic [W-1:0] ks[4];
        int cyc, bc;
        bit seen;
        logic [W-1:0] e;
        xs = '{8'hFF, 8'h80, 8'h80, 8'h05};
        ys = '{8'h02, 8'h80, 8'h7F, 8'hFD};
        ks = '{16'hFFFE, 16'h4000, 16'hC080, 16'hFFF1};
        for (int i = 0; i < 4; i++) begin
            issue(xs[i], ys[i]);
            wait_done(cyc, bc, seen);
            e = exp_q.pop_front();
            n_vec++;
            if (!seen || cyc !== N || result !== ks[i] || result !== e) begin
                n_miss++;
                $display("FAIL signed_%0d: seen=%b cyc=%0d result=%h want %h",
                         i, seen, cyc, result, ks[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
